// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared types and constants for the local injection arbiter.
package noc_local_inject_arbiter_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_FLIT_WIDTH = NOC_DATA_WIDTH + 2;
    localparam int FLIT_HDR_BIT   = NOC_FLIT_WIDTH - 1;
    localparam int FLIT_TAIL_BIT  = NOC_FLIT_WIDTH - 2;

    // Flit layout: {is_header, is_tail, data}
    typedef logic [NOC_FLIT_WIDTH-1:0] noc_flit_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Requester index reached by stepping 'offset' places from 'base', wrapping at n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/noc_local_inject_arbiter_if.sv
// Handshake bundle between the local flit sources and the router local port.
interface noc_local_inject_arbiter_if
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int FLIT_W = NOC_FLIT_WIDTH
) ();

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][FLIT_W-1:0] req_flit;
    logic [N_REQ-1:0]             req_ready;
    logic                         out_valid;
    logic [FLIT_W-1:0]            out_flit;
    logic                         out_ready;

    // Sources and router side
    modport master (
        output req_valid, req_flit, out_ready,
        input  req_ready, out_valid, out_flit
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_flit, out_ready,
        output req_ready, out_valid, out_flit
    );

endinterface

// File: rtl/noc_local_inject_arbiter_rr.sv
// Round-robin picker: first asserted request at or after the pointer.
module noc_rr_arbiter
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[rr_index(int'(ptr), k, N)]) begin
                any = 1'b1;
                idx = IDX_W'(rr_index(int'(ptr), k, N));
                gnt[rr_index(int'(ptr), k, N)] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one router local injection port.
// A source granted on its header owns the port until its tail. Non-owner
// body/tail flits and owner headers during a packet are consumed and dropped.
module noc_local_inject_arbiter
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int FLIT_W = NOC_FLIT_WIDTH,
    parameter int CNT_W  = 16,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst,
    noc_local_inject_arbiter_if.slave   bus,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        drop_pulse,
    output logic [IDX_W-1:0]            drop_id,
    output logic [N_REQ-1:0][CNT_W-1:0] pkt_cnt
);

    arb_state_e                  st_r, st_nxt;
    logic [IDX_W-1:0]            ptr_r, ptr_nxt, grant_id_r, grant_nxt;
    logic                        busy_r, out_valid_r, drop_pulse_r;
    logic [FLIT_W-1:0]           out_flit_r, load_flit_s;
    logic [IDX_W-1:0]            drop_id_r, drop_idx_s, cnt_idx_s, stray_idx_s, arb_idx_s;
    logic [N_REQ-1:0][CNT_W-1:0] pkt_cnt_r;
    logic [N_REQ-1:0]            hdr_s, stray_s, owner_mask_s, ready_s, arb_gnt_s;
    logic                        can_acc_s, arb_any_s, stray_any_s, load_s, cnt_inc_s, drop_s;

    assign can_acc_s    = !out_valid_r || bus.out_ready;
    assign owner_mask_s = (st_r == ST_LOCKED) ? (N_REQ'(1'b1) << grant_id_r) : '0;
    assign stray_s      = bus.req_valid & ~hdr_s & ~owner_mask_s;

    // Valid header flits per source (arbitration candidates).
    always_comb begin
        hdr_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hdr_s[i] = bus.req_valid[i] & bus.req_flit[i][FLIT_W-1];
        end
    end

    // Lowest-index stray source.
    always_comb begin
        stray_any_s = 1'b0;
        stray_idx_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (stray_s[i]) begin
                stray_any_s = 1'b1;
                stray_idx_s = IDX_W'(i);
            end else begin
                stray_any_s = stray_any_s;
            end
        end
    end

    noc_rr_arbiter #(.N(N_REQ)) u_rr (
        .req (hdr_s),
        .ptr (ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    // Next state, source accepts, output load, counter bump and drop selection.
    // req_ready is intentionally combinational from out_ready and req_valid.
    always_comb begin
        st_nxt      = st_r;
        ptr_nxt     = ptr_r;
        grant_nxt   = grant_id_r;
        ready_s     = '0;
        load_s      = 1'b0;
        load_flit_s = '0;
        cnt_inc_s   = 1'b0;
        cnt_idx_s   = grant_id_r;
        drop_s      = 1'b0;
        drop_idx_s  = '0;
        case (st_r)
            ST_IDLE: begin
                if (arb_any_s && can_acc_s) begin
                    ready_s     = arb_gnt_s;
                    load_s      = 1'b1;
                    load_flit_s = bus.req_flit[arb_idx_s];
                    grant_nxt   = arb_idx_s;
                    ptr_nxt     = (arb_idx_s == IDX_W'(N_REQ - 1)) ? '0 : arb_idx_s + 1'b1;
                    if (bus.req_flit[arb_idx_s][FLIT_W-2]) begin
                        cnt_inc_s = 1'b1;
                        cnt_idx_s = arb_idx_s;
                    end else begin
                        st_nxt = ST_LOCKED;
                    end
                end else begin
                    st_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (hdr_s[grant_id_r]) begin
                    // Owner restarted mid-packet: swallow the header, keep the lock.
                    ready_s[grant_id_r] = 1'b1;
                    drop_s              = 1'b1;
                    drop_idx_s          = grant_id_r;
                end else if (bus.req_valid[grant_id_r] && can_acc_s) begin
                    ready_s[grant_id_r] = 1'b1;
                    load_s              = 1'b1;
                    load_flit_s         = bus.req_flit[grant_id_r];
                    if (bus.req_flit[grant_id_r][FLIT_W-2]) begin
                        st_nxt    = ST_IDLE;
                        cnt_inc_s = 1'b1;
                    end else begin
                        st_nxt = ST_LOCKED;
                    end
                end else begin
                    st_nxt = ST_LOCKED;
                end
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
        // A stray waits only when an owner header already took this cycle's drop slot.
        if (!drop_s && stray_any_s) begin
            ready_s[stray_idx_s] = 1'b1;
            drop_s               = 1'b1;
            drop_idx_s           = stray_idx_s;
        end else begin
            drop_s = drop_s;
        end
    end

    // FSM, round-robin pointer, owner and busy flag.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            st_r       <= ST_IDLE;
            ptr_r      <= '0;
            grant_id_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            st_r       <= st_nxt;
            ptr_r      <= ptr_nxt;
            grant_id_r <= grant_nxt;
            busy_r     <= (st_nxt == ST_LOCKED);
        end
    end

    // Output flit register: load on accept, drain on out_ready, hold on stall.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            out_valid_r <= 1'b0;
            out_flit_r  <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_flit_r  <= load_flit_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Drop indication: one-cycle pulse, id held until the next drop.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            drop_pulse_r <= 1'b0;
            drop_id_r    <= '0;
        end else begin
            drop_pulse_r <= drop_s;
            if (drop_s) begin
                drop_id_r <= drop_idx_s;
            end
        end
    end

    // Saturating completed-packet counters.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            pkt_cnt_r <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (cnt_inc_s && (cnt_idx_s == IDX_W'(i)) && (pkt_cnt_r[i] != '1)) begin
                    pkt_cnt_r[i] <= pkt_cnt_r[i] + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_flit  = out_flit_r;
    assign grant_id      = grant_id_r;
    assign busy          = busy_r;
    assign drop_pulse    = drop_pulse_r;
    assign drop_id       = drop_id_r;
    assign pkt_cnt       = pkt_cnt_r;

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Bench for noc_local_inject_arbiter: scenario tasks with a cycle reference model
// and a per-source packet scoreboard on the output stream.
module tb_noc_local_inject_arbiter;
    import noc_local_inject_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int FW   = NOC_FLIT_WIDTH;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    noc_local_inject_arbiter_if #(.N_REQ(N), .FLIT_W(FW)) bus ();
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 drop_pulse;
    logic [1:0]           drop_id;
    logic [N-1:0][CW-1:0] pkt_cnt;

    noc_local_inject_arbiter #(.N_REQ(N), .FLIT_W(FW), .CNT_W(CW)) dut (
        .noc_clk    (clk),
        .noc_rst    (rst),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .drop_id    (drop_id),
        .pkt_cnt    (pkt_cnt)
    );

    typedef struct {
        logic [FW-1:0] flit;
        bit            fwd;
    } src_item_t;

    src_item_t     src_q[N][$];
    logic [FW-1:0] sb_q[N][$];
    bit            pres[N];
    bit            rand_gaps;
    int            hdr_log[$];
    int            cur_src;
    int            drops_seen[N];
    int            total = 0;
    int            bad = 0;

    // Reference model state (owner = -1 when no packet holds the port)
    bit            m_ov;
    logic [FW-1:0] m_of;
    int            m_owner, m_grant, m_ptr, m_drop, m_drop_id;
    int            m_cnt[N];

    function automatic logic [FW-1:0] mk_flit(input int src, input int seq, input int idx,
                                              input bit hdr, input bit tail);
        logic [3:0]  s4  = src[3:0];
        logic [11:0] q12 = seq[11:0];
        logic [15:0] i16 = idx[15:0];
        return {hdr, tail, s4, q12, i16};
    endfunction

    task automatic push_raw(input int src, input logic [FW-1:0] flit, input bit fwd);
        src_item_t it;
        it.flit = flit;
        it.fwd  = fwd;
        src_q[src].push_back(it);
        if (fwd) sb_q[src].push_back(flit);
    endtask

    task automatic push_pkt(input int src, input int seq, input int len);
        for (int k = 0; k < len; k++)
            push_raw(src, mk_flit(src, seq, k, k == 0, k == len - 1), 1'b1);
    endtask

    task automatic clear_all();
        m_ov = 1'b0; m_of = '0; m_owner = -1; m_grant = 0; m_ptr = 0;
        m_drop = 0; m_drop_id = 0; cur_src = -1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; pres[i] = 1'b0; drops_seen[i] = 0;
            src_q[i].delete(); sb_q[i].delete();
        end
        hdr_log.delete();
        bus.req_valid = '0; bus.req_flit = '0; bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: drive sources, predict accepts, check them, then check registered outputs.
    task automatic run_cycle(input bit ordy);
        logic [N-1:0]         v, er;
        logic [N-1:0][FW-1:0] f;
        logic [FW-1:0]        lf;
        bit                   can, load;
        int                   o, win, drop, s;
        v = '0; f = '0; er = '0; lf = '0; load = 1'b0; drop = -1; win = -1;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() == 0) pres[i] = 1'b0;
            else if (!pres[i]) pres[i] = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pres[i]) begin v[i] = 1'b1; f[i] = src_q[i][0].flit; end
        end
        bus.req_valid = v; bus.req_flit = f; bus.out_ready = ordy;
        #4;
        can = !m_ov || ordy;
        o   = m_owner;
        if (o < 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (win < 0 && v[j] && f[j][FW-1]) win = j;
            end
            if (win >= 0 && can) begin
                er[win] = 1'b1; load = 1'b1; lf = f[win];
                m_grant = win; m_ptr = (win + 1) % N;
                if (f[win][FW-2]) m_cnt[win] = (m_cnt[win] < CMAX) ? m_cnt[win] + 1 : CMAX;
                else m_owner = win;
            end
        end else if (v[o]) begin
            if (f[o][FW-1]) begin
                er[o] = 1'b1; drop = o;
            end else if (can) begin
                er[o] = 1'b1; load = 1'b1; lf = f[o];
                if (f[o][FW-2]) begin
                    m_owner = -1;
                    m_cnt[o] = (m_cnt[o] < CMAX) ? m_cnt[o] + 1 : CMAX;
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (drop < 0 && i != o && v[i] && !f[i][FW-1]) begin er[i] = 1'b1; drop = i; end
        total++;
        if (bus.req_ready !== er) begin
            bad++; $display("FAIL req_ready: got %b want %b at %0t", bus.req_ready, er, $time);
        end
        // Output stream scoreboard: whole packets, in per-source order.
        if (bus.out_valid === 1'b1 && ordy) begin
            s = int'(bus.out_flit[31:28]);
            total++;
            if (s >= N || sb_q[s].size() == 0 || bus.out_flit !== sb_q[s][0]) begin
                bad++; $display("FAIL out_stream: got %h unexpected at %0t", bus.out_flit, $time);
            end else begin
                void'(sb_q[s].pop_front());
                if (bus.out_flit[FW-1]) begin cur_src = s; hdr_log.push_back(s); end
                total++;
                if (s != cur_src) begin
                    bad++; $display("FAIL interleave: got src %0d want src %0d", s, cur_src);
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (er[i] && v[i]) begin void'(src_q[i].pop_front()); pres[i] = 1'b0; end
        if (load) begin m_ov = 1'b1; m_of = lf; end
        else if (ordy) m_ov = 1'b0;
        m_drop = (drop >= 0);
        if (drop >= 0) m_drop_id = drop;
        @(posedge clk); #1;
        total += 6;
        if (bus.out_valid !== m_ov) begin bad++; $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, m_ov, $time); end
        if (m_ov && bus.out_flit !== m_of) begin bad++; $display("FAIL out_flit: got %h want %h at %0t", bus.out_flit, m_of, $time); end
        if (grant_id !== 2'(m_grant)) begin bad++; $display("FAIL grant_id: got %0d want %0d at %0t", grant_id, m_grant, $time); end
        if (busy !== (m_owner >= 0)) begin bad++; $display("FAIL busy: got %b want %b at %0t", busy, m_owner >= 0, $time); end
        if (drop_pulse !== m_drop) begin bad++; $display("FAIL drop_pulse: got %b want %b at %0t", drop_pulse, m_drop, $time); end
        if (drop_id !== 2'(m_drop_id)) begin bad++; $display("FAIL drop_id: got %0d want %0d at %0t", drop_id, m_drop_id, $time); end
        if (drop_pulse === 1'b1) drops_seen[drop_id]++;
        for (int i = 0; i < N; i++) begin
            total++;
            if (pkt_cnt[i] !== 2'(m_cnt[i])) begin
                bad++; $display("FAIL pkt_cnt%0d: got %0d want %0d at %0t", i, pkt_cnt[i], m_cnt[i], $time);
            end
        end
    endtask

    task automatic drain(input int budget, input bit rnd);
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < budget) begin
            run_cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
            pending = m_ov;
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) pending = 1'b1;
        end
        total++;
        if (pending) begin bad++; $display("FAIL drain_timeout: got still busy after %0d cycles want idle", budget); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        @(posedge clk); #1;
        total += 8;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_flit !== '0) begin bad++; $display("FAIL reset_out_flit: got %h want 0", bus.out_flit); end
        if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop_pulse: got %b want 0", drop_pulse); end
        if (drop_id !== 2'd0) begin bad++; $display("FAIL reset_drop_id: got %0d want 0", drop_id); end
        if (pkt_cnt !== '0) begin bad++; $display("FAIL reset_pkt_cnt: got %h want 0", pkt_cnt); end
        if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        do_reset();
        rand_gaps = 1'b0;
        push_pkt(0, 1, 3);
        drain(20, 1'b0);
        total += 3;
        if (pkt_cnt[0] !== 2'd1) begin bad++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt[0]); end
        if (grant_id !== 2'd0) begin bad++; $display("FAIL single_grant: got %0d want 0", grant_id); end
        if (sb_q[0].size() != 0) begin bad++; $display("FAIL single_flits: got %0d left want 0", sb_q[0].size()); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) push_pkt(i, 10 + i, 3);
        drain(40, 1'b0);
        // Pointer should be back at 0: src0 beats src3 when both ask together.
        push_pkt(3, 20, 2);
        push_pkt(0, 21, 2);
        drain(20, 1'b0);
        total++;
        if (hdr_log.size() != 6) begin
            bad++; $display("FAIL rr_count: got %0d want 6", hdr_log.size());
        end else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (hdr_log[i] != i) begin bad++; $display("FAIL rr_order%0d: got %0d want %0d", i, hdr_log[i], i); end
            end
            total++;
            if (hdr_log[4] != 0) begin bad++; $display("FAIL rr_wrap: got %0d want 0", hdr_log[4]); end
        end
    endtask

    task automatic test_stray_drop();
        do_reset();
        push_pkt(2, 5, 5);
        run_cycle(1'b1);
        push_raw(1, mk_flit(1, 6, 1, 1'b0, 1'b0), 1'b0);
        push_raw(1, mk_flit(1, 6, 2, 1'b0, 1'b1), 1'b0);
        for (int c = 0; c < 12; c++) run_cycle(c[0] == 1'b0);
        drain(20, 1'b0);
        total += 2;
        if (drops_seen[1] != 2) begin bad++; $display("FAIL stray_drops: got %0d want 2", drops_seen[1]); end
        if (pkt_cnt[2] !== 2'd1) begin bad++; $display("FAIL stray_owner_pkt: got %0d want 1", pkt_cnt[2]); end
    endtask

    task automatic test_owner_header();
        do_reset();
        push_raw(0, mk_flit(0, 7, 0, 1'b1, 1'b0), 1'b1);
        push_raw(0, mk_flit(0, 8, 0, 1'b1, 1'b0), 1'b0);
        push_raw(0, mk_flit(0, 7, 1, 1'b0, 1'b0), 1'b1);
        push_raw(0, mk_flit(0, 7, 2, 1'b0, 1'b1), 1'b1);
        push_raw(1, mk_flit(1, 9, 0, 1'b0, 1'b1), 1'b0);
        drain(20, 1'b0);
        total += 3;
        if (drops_seen[0] != 1) begin bad++; $display("FAIL owner_hdr_drop: got %0d want 1", drops_seen[0]); end
        if (drops_seen[1] != 1) begin bad++; $display("FAIL owner_hdr_stray: got %0d want 1", drops_seen[1]); end
        if (pkt_cnt[0] !== 2'd1) begin bad++; $display("FAIL owner_hdr_pkt: got %0d want 1", pkt_cnt[0]); end
    endtask

    task automatic test_single_flit();
        do_reset();
        push_pkt(3, 1, 1);
        run_cycle(1'b1);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL sflit_busy: got %b want 0", busy); end
        push_pkt(0, 2, 2);
        run_cycle(1'b1);
        total++;
        if (grant_id !== 2'd0) begin bad++; $display("FAIL sflit_next_grant: got %0d want 0", grant_id); end
        drain(20, 1'b0);
        total++;
        if (pkt_cnt[3] !== 2'd1) begin bad++; $display("FAIL sflit_pkt_cnt: got %0d want 1", pkt_cnt[3]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_pkt(0, 1, 3);
        run_cycle(1'b1);
        run_cycle(1'b1);
        rst = 1'b1;
        #1;
        total += 2;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        clear_all();
        @(posedge clk); #1;
        rst = 1'b0;
        push_pkt(1, 2, 2);
        run_cycle(1'b1);
        total++;
        if (grant_id !== 2'd1) begin bad++; $display("FAIL midrst_grant: got %0d want 1", grant_id); end
        drain(20, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_pkt(2, p, 2);
            drain(20, 1'b0);
            if (p >= 2) begin
                total++;
                if (pkt_cnt[2] !== 2'd3) begin bad++; $display("FAIL sat_pkt%0d: got %0d want 3", p, pkt_cnt[2]); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_gaps = 1'b1;
        for (int p = 0; p < 60; p++) push_pkt($urandom_range(0, N - 1), p, $urandom_range(1, 4));
        drain(3000, 1'b1);
        for (int i = 0; i < N; i++) begin
            total++;
            if (sb_q[i].size() != 0) begin bad++; $display("FAIL rand_left%0d: got %0d want 0", i, sb_q[i].size()); end
        end
        rand_gaps = 1'b0;
    endtask

    initial begin
        rand_gaps = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_stray_drop();
        test_owner_header();
        test_single_flit();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
